rbm_train_seq: RTL
==================

Name: rbm_train_seq

Overview:
Sequences the RBM datapath through contrastive-divergence (CD-k) training, or inference-only passes, using the configuration fields exported by the control register block. It issues one operation at a time to the datapath over a valid/ready command channel and waits for a completion pulse before issuing the next. It produces the busy, done, error, batch-done and epoch-done status signals that the register block reads back and uses to raise interrupts.

Parameters:
CNT_W, 16, width of the sample, batch and epoch counters and their config inputs
K_W, 8, width of the Gibbs-step counter and k_dim
TIMEOUT, 65535, maximum cycles from op acceptance to op_done before the block flags an error

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ctrl_start  in  1  level input; a rising edge starts a run
ctrl_soft_rst  in  1  synchronous abort; returns the block to IDLE
ctrl_mode_train  in  1  1 = CD-k training, 0 = inference (LOAD and POS only)
batch_size  in  CNT_W  samples per batch
batches  in  CNT_W  batches per epoch
epochs  in  CNT_W  epoch count
k_dim  in  K_W  Gibbs steps per sample
op_valid  out  1  command valid
op_code  out  3  0 CLR, 1 LOAD, 2 POS, 3 H2V, 4 V2H, 5 NEG, 6 UPD
op_ready  in  1  datapath accepts the command
op_done  in  1  single-cycle completion pulse for the accepted op
sample_idx  out  CNT_W  global sample index (batch_idx*batch_size + sample), used for data addressing
stat_busy  out  1  run in progress
stat_done  out  1  sticky; run completed
stat_err  out  1  sticky; bad config or timeout
stat_batch_done  out  1  1-cycle pulse at the end of each batch
stat_epoch_done  out  1  1-cycle pulse at the end of each epoch

Behaviour:
- Reset (async assert, sync deassert use): every output is 0, state is IDLE, and all counters are 0.
- Start:
  - A start is a rising edge of ctrl_start (registered previous value), sampled in IDLE, DONE or ERR. It is ignored in any other state.
  - On a start, batch_size, batches, epochs, k_dim and mode are latched, and stat_done and stat_err are cleared.
- Config check on start:
  - Any of batch_size, batches or epochs equal to 0, or k_dim equal to 0 while mode_train = 1, moves the block to ERR.
  - In that case stat_err = 1 in the next cycle and no op is issued.
- States: IDLE, ISSUE, WAIT, NEXT, DONE, ERR.
  - ISSUE: drives op_valid = 1 with a stable op_code. On op_valid & op_ready, go to WAIT; op_valid is 0 in the following cycle.
  - WAIT: on op_done go to NEXT. The watchdog counts cycles spent in WAIT; reaching TIMEOUT moves to ERR. An op_done seen outside WAIT is ignored.
  - NEXT: a single cycle that advances the counters and selects the next op, then goes to ISSUE, DONE or IDLE-equivalent DONE.
- Latency:
  - Start edge at clock t gives stat_busy = 1, op_valid = 1 and op_code = CLR at t+1.
  - op_done at clock t gives op_valid for the next op at t+2 (one cycle spent in NEXT).
- Training order, per batch:
  - CLR.
  - For each sample: LOAD, POS, then {H2V, V2H} repeated k_dim times, then NEG.
  - After the last sample of the batch: UPD.
- Inference order, per batch: CLR, then {LOAD, POS} for each sample. There is no UPD.
- Batch end: stat_batch_done pulses in the NEXT cycle that follows the completion of UPD (training) or of the last POS (inference).
- Epoch end: stat_epoch_done pulses in the same cycle as the batch_done of the final batch of the epoch.
- Completion: after the last epoch the block enters DONE with stat_busy = 0 and stat_done = 1. stat_done stays set until the next start or a soft reset.
- sample_idx: resets to 0 at the start of each epoch, increments after each NEG (training) or POS (inference), and wraps modulo 2^CNT_W.
- Counter compare: each counter compares against (config - 1). Counters never overflow because of the nonzero check at start.
- ctrl_soft_rst: takes priority over everything. In the next cycle the state is IDLE, op_valid = 0, all status signals are 0 and all counters are cleared. An op already in flight is abandoned and its op_done is ignored.
- ERR: stat_busy = 0 and stat_err = 1. The block leaves ERR only through a start edge or a soft reset.
- Config inputs changing mid-run have no effect, because the values are latched at start.

Decomposition:
- Package rbm_pkg holds the op_code enum (rbm_op_e, 3 bits) and the state enum (rbm_seq_state_e), shared with the datapath and the testbench.
- One sub-module, rbm_seq_watchdog: a TIMEOUT counter with clear and enable inputs and an expired output.

Test Plan:
- Training, batch_size = 2, k_dim = 1, batches = 1, epochs = 1, op_ready tied to 1, op_done 3 cycles after accept:
  - exactly 12 ops: CLR, then {LOAD, POS, H2V, V2H, NEG} twice, then UPD.
  - one batch_done and one epoch_done, in the same cycle.
  - stat_done = 1 and stat_busy = 0 at the end.
- Inference, batch_size = 3, batches = 2, epochs = 2:
  - 4 × (CLR + 3 × {LOAD, POS}) = 28 ops and no UPD.
  - 4 batch_done pulses and 2 epoch_done pulses.
  - sample_idx runs 0..5 and then returns to 0 for the second epoch.
- op_ready held low for 5 cycles during ISSUE: op_valid and op_code stay stable, and exactly one op is accepted.
- Start with batch_size = 0: stat_err = 1 one cycle later and op_valid never asserts. A following valid start clears stat_err and runs normally.
- op_done withheld for TIMEOUT = 16 (parameter override) cycles: stat_err = 1, stat_busy = 0, op_valid = 0.
- Soft reset in WAIT during the V2H op:
  - next cycle: state IDLE and all outputs 0.
  - a late op_done is ignored.
  - a second ctrl_start rising edge, and ctrl_start held high while busy, each trigger exactly one run.

Source files
------------

// File: rtl/rbm_pkg.sv
// Shared encodings for the RBM training sequencer: datapath op codes and
// sequencer state values, used by the sequencer, the datapath and benches.
package rbm_pkg;

  typedef enum logic [2:0] {
    OP_CLR  = 3'd0,
    OP_LOAD = 3'd1,
    OP_POS  = 3'd2,
    OP_H2V  = 3'd3,
    OP_V2H  = 3'd4,
    OP_NEG  = 3'd5,
    OP_UPD  = 3'd6
  } rbm_op_e;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ISSUE = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_NEXT  = 3'd3,
    SEQ_DONE  = 3'd4,
    SEQ_ERR   = 3'd5
  } rbm_seq_state_e;

endpackage

// File: rtl/rbm_seq_watchdog.sv
// Op-completion watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT-th one. clr has priority and returns the count to zero.
module rbm_seq_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  assign expired = en && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/rbm_train_seq.sv
// CD-k training / inference sequencer: issues one datapath op at a time and
// reports busy, done, error, batch-done and epoch-done status.
module rbm_train_seq
  import rbm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int K_W     = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 ctrl_start,
  input  logic                 ctrl_soft_rst,
  input  logic                 ctrl_mode_train,
  input  logic [CNT_W-1:0]     batch_size,
  input  logic [CNT_W-1:0]     batches,
  input  logic [CNT_W-1:0]     epochs,
  input  logic [K_W-1:0]       k_dim,
  output logic                 op_valid,
  output logic [2:0]           op_code,
  input  logic                 op_ready,
  input  logic                 op_done,
  output logic [CNT_W-1:0]     sample_idx,
  output logic                 stat_busy,
  output logic                 stat_done,
  output logic                 stat_err,
  output logic                 stat_batch_done,
  output logic                 stat_epoch_done,
  output rbm_seq_state_e       dbg_state
);

  localparam logic [2:0] S_IDLE  = SEQ_IDLE;
  localparam logic [2:0] S_ISSUE = SEQ_ISSUE;
  localparam logic [2:0] S_WAIT  = SEQ_WAIT;
  localparam logic [2:0] S_NEXT  = SEQ_NEXT;
  localparam logic [2:0] S_DONE  = SEQ_DONE;
  localparam logic [2:0] S_ERR   = SEQ_ERR;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [K_W-1:0]   K_ONE   = {{(K_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  rbm_op_e          cur_op;
  logic             start_q;
  logic             mode_q;
  logic [CNT_W-1:0] bs_last, nb_last, ne_last;
  logic [K_W-1:0]   kd_last;
  logic [CNT_W-1:0] samp_cnt, batch_cnt, epoch_cnt;
  logic [K_W-1:0]   k_cnt;
  logic             start_edge, cfg_bad, batch_end, epoch_end;
  logic             wd_expired;

  assign start_edge = ctrl_start && !start_q;
  assign cfg_bad    = (batch_size == '0) || (batches == '0) || (epochs == '0) ||
                      (ctrl_mode_train && (k_dim == '0));

  assign batch_end = (state == S_NEXT) &&
                     ((cur_op == OP_UPD) ||
                      (!mode_q && (cur_op == OP_POS) && (samp_cnt == bs_last)));
  assign epoch_end = batch_end && (batch_cnt == nb_last);

  // Command channel: op_code is held stable while op_valid is high; the op is
  // transferred on the cycle where op_valid && op_ready, and op_valid drops next.
  assign op_valid        = (state == S_ISSUE);
  assign op_code         = op_valid ? cur_op : 3'd0;
  assign stat_busy       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);
  assign stat_done       = (state == S_DONE);
  assign stat_err        = (state == S_ERR);
  assign stat_batch_done = batch_end;
  assign stat_epoch_done = epoch_end;
  assign dbg_state       = rbm_seq_state_e'(state);

  rbm_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clr     (ctrl_soft_rst || (state != S_WAIT)),
    .en      (state == S_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      cur_op     <= OP_CLR;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      bs_last    <= '0;
      nb_last    <= '0;
      ne_last    <= '0;
      kd_last    <= '0;
      samp_cnt   <= '0;
      batch_cnt  <= '0;
      epoch_cnt  <= '0;
      k_cnt      <= '0;
      sample_idx <= '0;
    end else begin
      start_q <= ctrl_start;
      if (ctrl_soft_rst) begin
        state      <= S_IDLE;
        cur_op     <= OP_CLR;
        samp_cnt   <= '0;
        batch_cnt  <= '0;
        epoch_cnt  <= '0;
        k_cnt      <= '0;
        sample_idx <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start_edge) begin
              mode_q     <= ctrl_mode_train;
              bs_last    <= batch_size - CNT_ONE;
              nb_last    <= batches - CNT_ONE;
              ne_last    <= epochs - CNT_ONE;
              kd_last    <= k_dim - K_ONE;
              cur_op     <= OP_CLR;
              samp_cnt   <= '0;
              batch_cnt  <= '0;
              epoch_cnt  <= '0;
              k_cnt      <= '0;
              sample_idx <= '0;
              state      <= cfg_bad ? S_ERR : S_ISSUE;
            end
          end
          S_ISSUE: if (op_ready) state <= S_WAIT;
          S_WAIT: begin
            if (op_done)         state <= S_NEXT;
            else if (wd_expired) state <= S_ERR;
          end
          S_NEXT: begin
            state <= S_ISSUE;
            case (cur_op)
              OP_CLR:  cur_op <= OP_LOAD;
              OP_LOAD: cur_op <= OP_POS;
              OP_POS: begin
                if (mode_q) begin
                  cur_op <= OP_H2V;
                end else begin
                  sample_idx <= sample_idx + CNT_ONE;
                  if (samp_cnt == bs_last) begin
                    samp_cnt <= '0;
                  end else begin
                    samp_cnt <= samp_cnt + CNT_ONE;
                    cur_op   <= OP_LOAD;
                  end
                end
              end
              OP_H2V:  cur_op <= OP_V2H;
              OP_V2H: begin
                if (k_cnt == kd_last) begin
                  k_cnt  <= '0;
                  cur_op <= OP_NEG;
                end else begin
                  k_cnt  <= k_cnt + K_ONE;
                  cur_op <= OP_H2V;
                end
              end
              OP_NEG: begin
                sample_idx <= sample_idx + CNT_ONE;
                if (samp_cnt == bs_last) begin
                  samp_cnt <= '0;
                  cur_op   <= OP_UPD;
                end else begin
                  samp_cnt <= samp_cnt + CNT_ONE;
                  cur_op   <= OP_LOAD;
                end
              end
              default: cur_op <= OP_CLR;
            endcase
            // Batch/epoch rollover overrides the op selection above.
            if (batch_end) begin
              cur_op <= OP_CLR;
              if (batch_cnt == nb_last) begin
                batch_cnt  <= '0;
                sample_idx <= '0;
                if (epoch_cnt == ne_last) begin
                  epoch_cnt <= '0;
                  state     <= S_DONE;
                end else begin
                  epoch_cnt <= epoch_cnt + CNT_ONE;
                end
              end else begin
                batch_cnt <= batch_cnt + CNT_ONE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
